// File: rtl/cache_pkg.sv
// Shared state type and width helpers for the N-way tag/LRU lookup.
package cache_pkg;

  typedef enum logic {IDLE, WAIT} state_e;

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int tag_w(input int addr_w, input int off_w);
    return addr_w - off_w;
  endfunction

endpackage

// File: rtl/lru_matrix.sv
// Age matrix for true LRU: m[i][j]=1 means way i is older than way j.
module lru_matrix
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             clr,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             demote,
  input  logic [WAY_W-1:0] demote_way,
  output logic [WAY_W-1:0] lru_way
);

  logic [WAYS-1:0] m_q [WAYS];
  logic [WAYS-1:0] m_d [WAYS];

  always_comb begin
    for (int i = 0; i < WAYS; i++) m_d[i] = m_q[i];
    if (touch) begin
      m_d[touch_way] = '0;
      for (int i = 0; i < WAYS; i++)
        m_d[i][touch_way] = 1'b1;
    end else if (demote) begin
      for (int i = 0; i < WAYS; i++)
        m_d[i][demote_way] = 1'b0;
      m_d[demote_way] = '1;
    end
  end

  // Exactly one row is all ones; the scan keeps the lowest for safety.
  always_comb begin
    lru_way = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (&m_q[i]) lru_way = WAY_W'(i);
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i || clr) begin
      for (int i = 0; i < WAYS; i++)
        for (int j = 0; j < WAYS; j++)
          m_q[i][j] <= (i <= j);
    end else begin
      for (int i = 0; i < WAYS; i++)
        m_q[i] <= m_d[i];
    end
  end

endmodule

// File: rtl/cache_lookup_nway.sv
// Fully associative tag/valid lookup with LRU victim choice and refill FSM.
module cache_lookup_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int OFFSET_W = 4,
  parameter int WAYS = 4,
  parameter int WRITE_POLICY = 0,
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              read_rqst_i,
  input  logic              write_rqst_i,
  input  logic              rqst_byte_i,
  input  logic              flush_i,
  input  logic              mem_data_ready_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  output logic              hit_o,
  output logic              miss_o,
  output logic [WAY_W-1:0]  hit_way_o,
  output logic [WAY_W-1:0]  lru_way_o,
  output logic              rqst_to_mem_o,
  output logic [ADDR_W-1:0] addr_to_mem_o,
  output logic              fill_o,
  output logic              busy_o,
  output logic              unalign_o
);

  localparam int TAG_W = tag_w(ADDR_W, OFFSET_W);
  localparam bit WB = (WRITE_POLICY != 0);

  state_e           state_q;
  logic [TAG_W-1:0] tag_q [WAYS];
  logic [WAYS-1:0]  valid_q;
  logic [WAYS-1:0]  match;
  logic [TAG_W-1:0] rq_tag;
  logic [TAG_W-1:0] mem_tag;
  logic [TAG_W-1:0] miss_tag;
  logic [WAY_W-1:0] hit_idx;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] touch_way;
  logic             hit;
  logic             idle;
  logic             do_flush;
  logic             do_read;
  logic             do_write;
  logic             fill_ok;
  logic             touch;
  logic             demote;
  logic             unused_ok;

  assign rq_tag   = addr_i[ADDR_W-1:OFFSET_W];
  assign mem_tag  = mem_addr_i[ADDR_W-1:OFFSET_W];
  assign miss_tag = addr_to_mem_o[ADDR_W-1:OFFSET_W];
  assign unused_ok =
    ^{addr_i[OFFSET_W-1:2], mem_addr_i[OFFSET_W-1:0]};

  assign unalign_o = (read_rqst_i || write_rqst_i)
    && !rqst_byte_i && (addr_i[1:0] != 2'b00);

  assign idle     = (state_q == IDLE);
  assign busy_o   = !idle;
  assign miss_o   = !idle;
  assign do_flush = idle && flush_i;
  assign do_read  = idle && !flush_i && !unalign_o
    && read_rqst_i;
  assign do_write = idle && !flush_i && !unalign_o
    && !read_rqst_i && write_rqst_i;
  assign fill_ok  = !idle && mem_data_ready_i
    && (mem_tag == miss_tag);

  always_comb begin
    for (int i = 0; i < WAYS; i++)
      match[i] = valid_q[i] && (tag_q[i] == rq_tag);
  end

  assign hit = |match;

  // Lowest index wins for both the hit way and invalid-first victim.
  always_comb begin
    hit_idx = '0;
    victim  = lru_way;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = WAY_W'(i);
      if (!valid_q[i]) victim = WAY_W'(i);
    end
  end

  always_comb begin
    touch     = 1'b0;
    demote    = 1'b0;
    touch_way = hit_idx;
    unique case (1'b1)
      fill_ok: begin
        touch     = 1'b1;
        touch_way = lru_way_o;
      end
      do_read:  touch = hit;
      do_write: begin
        touch  = hit && WB;
        demote = hit && !WB;
      end
      default: ;
    endcase
  end

  lru_matrix #(.WAYS(WAYS)) u_lru (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .clr        (do_flush),
    .touch      (touch),
    .touch_way  (touch_way),
    .demote     (demote),
    .demote_way (hit_idx),
    .lru_way    (lru_way)
  );

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      hit_o         <= 1'b0;
      hit_way_o     <= '0;
      lru_way_o     <= '0;
      rqst_to_mem_o <= 1'b0;
      addr_to_mem_o <= '0;
      fill_o        <= 1'b0;
    end else begin
      hit_o         <= 1'b0;
      rqst_to_mem_o <= 1'b0;
      fill_o        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (do_flush) begin
            valid_q <= '0;
          end else if (do_read && hit) begin
            hit_o     <= 1'b1;
            hit_way_o <= hit_idx;
          end else if (do_read) begin
            addr_to_mem_o <= addr_i;
            lru_way_o     <= victim;
            rqst_to_mem_o <= 1'b1;
            state_q       <= WAIT;
          end else if (do_write && hit) begin
            if (WB) begin
              hit_o     <= 1'b1;
              hit_way_o <= hit_idx;
            end else begin
              valid_q[hit_idx] <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (fill_ok) begin
            tag_q[lru_way_o]   <= miss_tag;
            valid_q[lru_way_o] <= 1'b1;
            fill_o             <= 1'b1;
            state_q            <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lookup_nway.sv
// Self-checking bench: directed table, hand sequences, random vs. model.
module tb_cache_lookup_nway;

  localparam int AW = 20;
  localparam int OW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rsn = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic          byt = 1'b0;
  logic          flush = 1'b0;
  logic          mrdy = 1'b0;
  logic [AW-1:0] maddr = '0;

  logic [1:0]    hit, miss, busy, rq, fill, unal;
  logic [1:0]    hway [2];
  logic [1:0]    lway [2];
  logic [AW-1:0] a2m [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_lookup_nway #(
    .ADDR_W(AW), .OFFSET_W(OW), .WAYS(NW), .WRITE_POLICY(0)
  ) u0 (
    .clk_i(clk), .rsn_i(rsn), .addr_i(addr),
    .read_rqst_i(rd), .write_rqst_i(wr), .rqst_byte_i(byt),
    .flush_i(flush), .mem_data_ready_i(mrdy), .mem_addr_i(maddr),
    .hit_o(hit[0]), .miss_o(miss[0]), .hit_way_o(hway[0]),
    .lru_way_o(lway[0]), .rqst_to_mem_o(rq[0]),
    .addr_to_mem_o(a2m[0]), .fill_o(fill[0]), .busy_o(busy[0]),
    .unalign_o(unal[0])
  );

  cache_lookup_nway #(
    .ADDR_W(AW), .OFFSET_W(OW), .WAYS(NW), .WRITE_POLICY(1)
  ) u1 (
    .clk_i(clk), .rsn_i(rsn), .addr_i(addr),
    .read_rqst_i(rd), .write_rqst_i(wr), .rqst_byte_i(byt),
    .flush_i(flush), .mem_data_ready_i(mrdy), .mem_addr_i(maddr),
    .hit_o(hit[1]), .miss_o(miss[1]), .hit_way_o(hway[1]),
    .lru_way_o(lway[1]), .rqst_to_mem_o(rq[1]),
    .addr_to_mem_o(a2m[1]), .fill_o(fill[1]), .busy_o(busy[1]),
    .unalign_o(unal[1])
  );

  // Reference model: recency kept as an ordered list, front = oldest.
  bit            mv [2][NW];
  int            mt [2][NW];
  int            ord [2][NW];
  bit            mw [2];
  bit            eh [2];
  bit            erq [2];
  bit            ef [2];
  int            ehw [2];
  int            elw [2];
  logic [AW-1:0] ea [2];

  task automatic m_touch(input int p, input int w);
    int k = 0;
    for (int i = 0; i < NW; i++) if (ord[p][i] == w) k = i;
    for (int i = k; i < NW - 1; i++) ord[p][i] = ord[p][i+1];
    ord[p][NW-1] = w;
  endtask

  task automatic m_demote(input int p, input int w);
    int k = 0;
    for (int i = 0; i < NW; i++) if (ord[p][i] == w) k = i;
    for (int i = k; i > 0; i--) ord[p][i] = ord[p][i-1];
    ord[p][0] = w;
  endtask

  task automatic m_clear(input int p);
    for (int i = 0; i < NW; i++) begin
      mv[p][i] = 1'b0;
      ord[p][i] = i;
    end
  endtask

  function automatic int m_find(input int p, input int t);
    int w = -1;
    for (int i = NW - 1; i >= 0; i--)
      if (mv[p][i] && mt[p][i] == t) w = i;
    return w;
  endfunction

  function automatic int m_victim(input int p);
    int w = ord[p][0];
    for (int i = NW - 1; i >= 0; i--) if (!mv[p][i]) w = i;
    return w;
  endfunction

  function automatic bit exp_unal();
    return (rd || wr) && !byt && (addr[1:0] != 2'b00);
  endfunction

  task automatic m_step(input int p);
    int t;
    int w;
    t = int'(addr >> OW);
    eh[p] = 1'b0;
    erq[p] = 1'b0;
    ef[p] = 1'b0;
    if (!rsn) begin
      m_clear(p);
      mw[p] = 1'b0;
      ehw[p] = 0;
      elw[p] = 0;
      ea[p] = '0;
    end else if (!mw[p]) begin
      if (flush) begin
        m_clear(p);
      end else if (exp_unal()) begin
      end else if (rd) begin
        w = m_find(p, t);
        if (w >= 0) begin
          eh[p] = 1'b1;
          ehw[p] = w;
          m_touch(p, w);
        end else begin
          ea[p] = addr;
          elw[p] = m_victim(p);
          erq[p] = 1'b1;
          mw[p] = 1'b1;
        end
      end else if (wr) begin
        w = m_find(p, t);
        if (w >= 0 && p == 0) begin
          mv[p][w] = 1'b0;
          m_demote(p, w);
        end else if (w >= 0) begin
          eh[p] = 1'b1;
          ehw[p] = w;
          m_touch(p, w);
        end
      end
    end else if (mrdy && (maddr >> OW) == (ea[p] >> OW)) begin
      mt[p][elw[p]] = int'(ea[p] >> OW);
      mv[p][elw[p]] = 1'b1;
      m_touch(p, elw[p]);
      mw[p] = 1'b0;
      ef[p] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    m_step(0);
    m_step(1);
  end

  function automatic logic [29:0] act_vec(input int p);
    return {hit[p], miss[p], busy[p], hway[p], lway[p],
            rq[p], a2m[p], fill[p], unal[p]};
  endfunction

  function automatic logic [29:0] exp_vec(input int p);
    return {eh[p], mw[p], mw[p], 2'(ehw[p]), 2'(elw[p]),
            erq[p], ea[p], ef[p], exp_unal()};
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      n_chk++;
      if (act_vec(p) !== exp_vec(p)) begin
        n_fail++;
        $display("FAIL model p%0d @%0t: got %h want %h",
                 p, $time, act_vec(p), exp_vec(p));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd = 1'b1;
    addr = a;
    step();
    rd = 1'b0;
  endtask

  task automatic refill(input logic [AW-1:0] a);
    mrdy = 1'b1;
    maddr = a;
    step();
    mrdy = 1'b0;
  endtask

  typedef struct {
    int            op;
    logic [AW-1:0] a;
    bit            byt;
    bit            unal;
    bit            hit;
    bit            miss;
    logic [1:0]    way;
  } vec_t;

  localparam int NT = 15;
  vec_t tbl [NT];

  initial begin
    tbl[0]  = '{1, 20'h00010, 0, 0, 0, 1, 2'd0};
    tbl[1]  = '{1, 20'h0001C, 0, 0, 1, 0, 2'd0};
    tbl[2]  = '{1, 20'h00020, 0, 0, 0, 1, 2'd1};
    tbl[3]  = '{1, 20'h00030, 0, 0, 0, 1, 2'd2};
    tbl[4]  = '{1, 20'h00040, 0, 0, 0, 1, 2'd3};
    tbl[5]  = '{1, 20'h00010, 0, 0, 1, 0, 2'd0};
    tbl[6]  = '{1, 20'h00050, 0, 0, 0, 1, 2'd1};
    tbl[7]  = '{1, 20'h00020, 0, 0, 0, 1, 2'd2};
    tbl[8]  = '{1, 20'h00012, 0, 1, 0, 0, 2'd0};
    tbl[9]  = '{1, 20'h00012, 1, 0, 1, 0, 2'd0};
    tbl[10] = '{3, 20'h00000, 0, 0, 0, 0, 2'd0};
    tbl[11] = '{1, 20'h00010, 0, 0, 0, 1, 2'd0};
    tbl[12] = '{1, 20'h00050, 0, 0, 0, 1, 2'd1};
    tbl[13] = '{1, 20'h00020, 0, 0, 0, 1, 2'd2};
    tbl[14] = '{1, 20'h00040, 0, 0, 0, 1, 2'd3};

    step();
    step();
    chk("reset p0", 32'(act_vec(0)), 32'd0);
    chk("reset p1", 32'(act_vec(1)), 32'd0);
    rsn = 1'b1;
    step();

    for (int i = 0; i < NT; i++) begin
      rd = (tbl[i].op == 1);
      flush = (tbl[i].op == 3);
      addr = tbl[i].a;
      byt = tbl[i].byt;
      #1;
      chk($sformatf("v%0d unal", i), 32'(unal[0]), 32'(tbl[i].unal));
      step();
      rd = 1'b0;
      flush = 1'b0;
      byt = 1'b0;
      chk($sformatf("v%0d hit", i), 32'(hit[0]), 32'(tbl[i].hit));
      chk($sformatf("v%0d miss", i), 32'(miss[0]), 32'(tbl[i].miss));
      chk($sformatf("v%0d rqst", i), 32'(rq[0]), 32'(tbl[i].miss));
      if (tbl[i].hit)
        chk($sformatf("v%0d hway", i), 32'(hway[0]), 32'(tbl[i].way));
      if (tbl[i].miss) begin
        chk($sformatf("v%0d lway", i), 32'(lway[0]), 32'(tbl[i].way));
        chk($sformatf("v%0d a2m", i), 32'(a2m[0]), 32'(tbl[i].a));
        refill(tbl[i].a ^ 20'h00008);
        chk($sformatf("v%0d fill", i), 32'(fill[0]), 32'd1);
        chk($sformatf("v%0d busy", i), 32'(busy[0]), 32'd0);
      end
      step();
    end

    // Non-matching refill must be ignored.
    do_read(20'h00100);
    chk("nm miss", 32'(miss[0]), 32'd1);
    step();
    refill(20'h00200);
    chk("nm miss held", 32'(miss[0]), 32'd1);
    chk("nm busy held", 32'(busy[0]), 32'd1);
    chk("nm no fill", 32'(fill[0]), 32'd0);
    refill(20'h00104);
    chk("nm fill", 32'(fill[0]), 32'd1);
    chk("nm miss clr", 32'(miss[0]), 32'd0);
    step();

    // Write hit under both write policies.
    flush = 1'b1;
    step();
    flush = 1'b0;
    do_read(20'h00010);
    refill(20'h00010);
    do_read(20'h00020);
    chk("wp lway", 32'(lway[0]), 32'd1);
    refill(20'h00020);
    step();
    wr = 1'b1;
    addr = 20'h00024;
    step();
    wr = 1'b0;
    chk("wp0 write hit", 32'(hit[0]), 32'd0);
    chk("wp1 write hit", 32'(hit[1]), 32'd1);
    chk("wp1 write way", 32'(hway[1]), 32'd1);
    do_read(20'h00020);
    chk("wp0 read miss", 32'(miss[0]), 32'd1);
    chk("wp0 read lway", 32'(lway[0]), 32'd1);
    chk("wp1 read hit", 32'(hit[1]), 32'd1);
    chk("wp1 read way", 32'(hway[1]), 32'd1);
    refill(20'h00020);
    chk("wp0 refill", 32'(fill[0]), 32'd1);
    step();

    // Flush in WAIT is ignored; reset in WAIT aborts the refill.
    do_read(20'h00700);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fw busy", 32'(busy[0]), 32'd1);
    refill(20'h00700);
    chk("fw fill", 32'(fill[0]), 32'd1);
    step();
    do_read(20'h00704);
    chk("fw hit", 32'(hit[0]), 32'd1);
    step();
    do_read(20'h00800);
    chk("rw miss", 32'(miss[0]), 32'd1);
    rsn = 1'b0;
    step();
    rsn = 1'b1;
    chk("rw miss clr", 32'(miss[0]), 32'd0);
    chk("rw busy clr", 32'(busy[0]), 32'd0);
    chk("rw outs", 32'(act_vec(0)), 32'd0);
    refill(20'h00800);
    chk("rw late fill", 32'(fill[0]), 32'd0);
    step();

    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [3:0] off;
      r = int'($urandom_range(0, 99));
      rd = (r < 30);
      wr = (r >= 30 && r < 45);
      flush = (r == 99);
      off = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) off[1:0] = 2'b00;
      addr = 20'($urandom_range(0, 7) * 16) | 20'(off);
      byt = 1'($urandom_range(0, 1));
      mrdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0)
        maddr = a2m[$urandom_range(0, 1)] ^ 20'($urandom_range(0, 15));
      else
        maddr = 20'($urandom_range(0, 7) * 16);
      rsn = ($urandom_range(0, 199) != 0);
      step();
    end

    rd = 1'b0;
    wr = 1'b0;
    flush = 1'b0;
    mrdy = 1'b0;
    rsn = 1'b1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_lookup_nway.md
# cache_lookup_nway

Parametrised N-way fully associative tag/LRU lookup controller for the first-level cache. It is the generalised successor of the fixed 4-way lookup, with configurable address width, line size and way count. It adds invalid-first victim selection, a latched miss address, a write-policy mode, flush and unaligned-request rejection. It sits between the core's load/store request port and the memory refill path; the data array lives outside the block and is indexed by `hit_way_o` / `lru_way_o`.

## Interface
Clock is `clk_i`; reset `rsn_i` is synchronous and active-low. One clock domain only.

Parameters:
- `ADDR_W`, default 20: request address width.
- `OFFSET_W`, default 4: line offset bits. Tag is `addr[ADDR_W-1:OFFSET_W]`, so `TAG_W = ADDR_W-OFFSET_W`.
- `WAYS`, default 4: number of ways, 2..16. `WAY_W = $clog2(WAYS)`.
- `WRITE_POLICY`, default 0:
  - 0: a write hit invalidates the way.
  - 1: a write hit keeps the way valid and promotes it to MRU.

Ports:
- `clk_i` in 1: clock.
- `rsn_i` in 1: synchronous active-low reset.
- `addr_i` in ADDR_W: request address.
- `read_rqst_i` in 1: read request.
- `write_rqst_i` in 1: write request.
- `rqst_byte_i` in 1: byte access; 0 means word access.
- `flush_i` in 1: invalidate all ways.
- `mem_data_ready_i` in 1: refill data valid.
- `mem_addr_i` in ADDR_W: refill address.
- `hit_o` out 1: lookup hit, one-cycle pulse.
- `miss_o` out 1: miss outstanding.
- `hit_way_o` out WAY_W: way of the last hit.
- `lru_way_o` out WAY_W: victim/fill way of the current miss.
- `rqst_to_mem_o` out 1: refill request, one-cycle pulse.
- `addr_to_mem_o` out ADDR_W: latched miss address.
- `fill_o` out 1: tag installed, one-cycle pulse.
- `busy_o` out 1: high in WAIT; new requests are ignored.
- `unalign_o` out 1: word request with `addr_i[1:0] != 0`; combinational.

## Operation
- States: IDLE and WAIT.
- Priority in IDLE: `flush_i` > unaligned reject > `read_rqst_i` > `write_rqst_i`.
- Hit: `valid[w] && tag[w] == addr_i` tag. At most one way matches by construction; if several match, the lowest index wins.

**LRU**
- Stored as a WAYS×WAYS matrix; `m[i][j] = 1` means way i is older than way j. The diagonal is always 1.
- Touching way w: clear row w, set column w. Way w becomes MRU.
- Demoting way w: clear column w, set row w. Way w becomes LRU.
- The LRU way is the row whose AND over all bits is 1.
- Victim: the lowest-index invalid way if any exists, else the LRU way.

**Read (IDLE)**
- Hit: pulse `hit_o`, update `hit_way_o`, touch the way.
- Miss:
  - Latch `addr_i` into `addr_to_mem_o`.
  - Latch the victim into `lru_way_o`.
  - Pulse `rqst_to_mem_o`, set `miss_o`, go to WAIT.

**Write (IDLE)**
- Hit with `WRITE_POLICY=0`: clear the valid bit and demote the way; no `hit_o`.
- Hit with `WRITE_POLICY=1`: touch the way and pulse `hit_o`.
- Miss: no action (no write-allocate).

**Unaligned word request:** `unalign_o=1`; no lookup, no LRU change, no hit or miss.

**WAIT**
- Refill completes only when `mem_data_ready_i=1` and the `mem_addr_i` tag equals the latched tag. Then:
  - write the tag into `lru_way_o`, set its valid bit, touch it;
  - go to IDLE and pulse `fill_o`.
- `mem_data_ready_i` with a non-matching tag is ignored.
- `read_rqst_i`, `write_rqst_i` and `flush_i` are ignored in WAIT. The requester re-issues after `busy_o` falls.

**Flush (IDLE only):** clears all valid bits and restores the reset LRU matrix in one cycle.

## Timing
- Request sampled at edge N (IDLE). In cycle N+1:
  - a hit shows `hit_o=1` for exactly one cycle;
  - a miss shows `miss_o=1`, `busy_o=1`, `rqst_to_mem_o=1` for one cycle.
- Matching refill sampled at edge F:
  - cycle F+1: `fill_o=1`, `miss_o=0`, `busy_o=0`;
  - a request at edge F+1 sees the new tag (hit).
- `mem_data_ready_i` arriving in the same cycle as `rqst_to_mem_o` is accepted.
- Reset values:
  - all outputs 0;
  - all valid bits 0;
  - LRU matrix `m[i][j] = (i <= j)`, so way 0 is LRU and way WAYS-1 is MRU.
- Reset asserted mid-WAIT: at the next edge go to IDLE with all reset values; a late refill is ignored.

## Structure
- `cache_pkg` holds the state enum (IDLE, WAIT) and the `clog2`-based `WAY_W`/`TAG_W` helper functions.
- Sub-module `lru_matrix`, parametrised by `WAYS`:
  - inputs: touch enable/way, demote enable/way, reset;
  - output: `lru_way`.
- The top level holds the tag/valid registers, hit compare, victim priority encoder and FSM.

## Test plan
All scenarios use `WAYS=4`, `ADDR_W=20`, `OFFSET_W=4`.

1. **Cold miss and refill:** after reset, read 0x00010.
   - Next cycle: `miss_o=1`, `rqst_to_mem_o` pulses once, `addr_to_mem_o=0x00010`, `lru_way_o=0`.
   - Ready with `mem_addr_i=0x00018`: `fill_o` pulses.
   - Read 0x0001C: `hit_o=1`, `hit_way_o=0`.
2. **LRU victim choice:** fill tags 1..4 into ways 0..3, then read tag 1 (hit, way 0).
   - Read tag 5: `lru_way_o=1`.
   - Refill, then read tag 2: miss.
3. **Non-matching refill:** while waiting on 0x00100, ready with 0x00200 is ignored; `miss_o` and `busy_o` stay 1.
   - A following ready with 0x00104 completes the refill.
4. **Write hit, both policies:** write hit on tag 2 (way 1).
   - `WRITE_POLICY=0`: no `hit_o`; reading tag 2 misses with `lru_way_o=1`.
   - `WRITE_POLICY=1`: `hit_o` pulses; reading tag 2 hits on way 1.
5. **Unaligned reject:** read 0x00012 with `rqst_byte_i=0`.
   - `unalign_o=1`, no hit, no miss, no memory request.
   - Same address with `rqst_byte_i=1`: normal lookup.
6. **Flush and reset:** flush in IDLE, then re-read the four cached tags: all miss.
   - `flush_i` during WAIT is ignored.
   - `rsn_i=0` during WAIT: next cycle `miss_o=0`, `busy_o=0`, and a late refill causes no `fill_o`.
